// File: rtl/add_digit_serial_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
// Imported by the top level and the per-digit adder.
package add_digit_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // A single-digit configuration still needs a one-bit counter.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/add_digit_serial_digit.sv
// One DIGIT-bit ripple slice; the top level time-multiplexes it
// across all digits of the operands.
module add_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    logic [DIGIT:0] sum_w;

    always_comb begin
        sum_w = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
    end

    assign s    = sum_w[DIGIT-1:0];
    assign cout = sum_w[DIGIT];

endmodule

// File: rtl/add_digit_serial.sv
// Digit-serial adder: SUM = A + B + CI computed DIGIT bits per clock,
// least-significant digit first, with valid/ready on both sides.
module add_digit_serial
    import add_digit_serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] SUM,
    output logic             CO
);

    localparam int NDIG = ndig(WIDTH, DIGIT);
    localparam int CW   = cnt_w(NDIG);

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("add_digit_serial: WIDTH must be a multiple of DIGIT");
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             co_q, co_d;
    logic             out_valid_q, out_valid_d;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT-1:0] s_dig;
    logic             c_dig;
    logic             last_dig;

    // Operand slice selected by the digit counter.
    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (cnt_q == CW'(i)) begin
                a_dig = a_q[i*DIGIT +: DIGIT];
                b_dig = b_q[i*DIGIT +: DIGIT];
            end
        end
    end

    add_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a    (a_dig),
        .b    (b_dig),
        .cin  (carry_q),
        .s    (s_dig),
        .cout (c_dig)
    );

    assign last_dig = (cnt_q == CW'(NDIG - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        co_d        = co_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = CI;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int i = 0; i < NDIG; i++) begin
                    if (cnt_q == CW'(i)) begin
                        sum_d[i*DIGIT +: DIGIT] = s_dig;
                    end
                end
                carry_d = c_dig;
                if (last_dig) begin
                    co_d        = c_dig;
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            co_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            co_q        <= co_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Ready follows IDLE directly so it rises on the first cycle out of reset.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign SUM       = sum_q;
    assign CO        = co_q;

endmodule

// File: tb/tb_add_digit_serial.sv
// Scoreboard bench: directed vectors on the default instance plus
// random sweeps on DIGIT = 1, 2, 8 instances.
module tb_add_digit_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] s;
        logic       c;
        int         acc;
    } exp_t;

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endfunction

    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       co;

    add_digit_serial dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .CI        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .SUM       (sum),
        .CO        (co)
    );

    exp_t q0[$];
    int   acc_log[$];
    logic ov_prev0 = 1'b0;
    bit   done [3];

    always @(negedge clk) begin : mon0
        exp_t e;
        if (rst) begin
            ov_prev0 <= 1'b0;
        end else begin
            if (out_valid && !ov_prev0) begin
                if (q0.size() == 0) chk("spurious_out", 32'(out_valid), 0);
                else chk("latency", cyc - q0[0].acc, 2);
            end
            if (out_valid && out_ready && q0.size() != 0) begin
                e = q0.pop_front();
                chk("sum", 32'(sum), 32'(e.s));
                chk("co", 32'(co), 32'(e.c));
            end
            ov_prev0 <= out_valid;
        end
    end

    // Called just after a rising edge; returns just after the accept edge.
    task automatic send(input logic [7:0] av, input logic [7:0] bv,
                        input logic cv);
        bit got;
        logic [8:0] t;
        got = 1'b0;
        a = av;
        b = bv;
        ci = cv;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                t = {1'b0, av} + {1'b0, bv} + {8'b0, cv};
                q0.push_back('{t[7:0], t[8], cyc + 1});
                acc_log.push_back(cyc + 1);
            end
            @(posedge clk);
            #1;
        end
        if (!got) chk("accept_timeout", 32'(in_ready), 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && q0.size() != 0; k++) @(negedge clk);
        if (q0.size() != 0) chk("drain_timeout", q0.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit all_done;
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        ci = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_co", 32'(co), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;

        send(8'h5A, 8'h3C, 1'b0);
        in_valid = 1'b0;
        drain();
        send(8'hFF, 8'h01, 1'b0);
        in_valid = 1'b0;
        drain();
        send(8'hFF, 8'hFF, 1'b1);
        in_valid = 1'b0;
        drain();
        send(8'h0F, 8'h00, 1'b1);
        in_valid = 1'b0;
        drain();

        // Backpressure: result held while the consumer stalls.
        out_ready = 1'b0;
        send(8'hC8, 8'h64, 1'b0);
        in_valid = 1'b0;
        for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_sum", 32'(sum), 32'h2C);
            chk("bp_co", 32'(co), 1);
            chk("bp_in_ready", 32'(in_ready), 0);
            @(posedge clk);
            #1;
            in_valid = ~in_valid;
            a = 8'h11;
            b = 8'h22;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_idle_out_valid", 32'(out_valid), 0);
        chk("bp_idle_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        chk("bp_queue_empty", q0.size(), 0);

        // Back-to-back with in_valid and out_ready held high.
        acc_log.delete();
        send(8'h12, 8'h34, 1'b0);
        send(8'h80, 8'h80, 1'b0);
        send(8'h99, 8'h66, 1'b1);
        send(8'hA5, 8'h5A, 1'b0);
        in_valid = 1'b0;
        drain();
        for (int i = 1; i < acc_log.size(); i++)
            chk("b2b_spacing", acc_log[i] - acc_log[i-1], 4);

        // Reset while BUSY aborts the operation.
        send(8'h12, 8'h34, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        q0.delete();
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_sum", 32'(sum), 0);
        chk("midrst_co", 32'(co), 0);
        chk("midrst_in_ready_after", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        send(8'h01, 8'h01, 1'b0);
        in_valid = 1'b0;
        drain();

        all_done = 1'b0;
        for (int k = 0; k < 20000 && !all_done; k++) begin
            @(negedge clk);
            all_done = done[0] && done[1] && done[2];
        end
        if (!all_done) chk("sweep_timeout", 32'(all_done), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    for (genvar g = 0; g < 3; g++) begin : sw
        localparam int D = (g == 0) ? 1 : ((g == 1) ? 2 : 8);
        localparam int N = 8 / D;

        logic       srst;
        logic       siv;
        logic       sir;
        logic [7:0] sa;
        logic [7:0] sb;
        logic       sci;
        logic       sov;
        logic [7:0] ssum;
        logic       sco;
        exp_t       sq[$];
        logic       sprev = 1'b0;

        add_digit_serial #(
            .WIDTH (8),
            .DIGIT (D)
        ) dut_s (
            .clk       (clk),
            .rst       (srst),
            .in_valid  (siv),
            .in_ready  (sir),
            .A         (sa),
            .B         (sb),
            .CI        (sci),
            .out_valid (sov),
            .out_ready (1'b1),
            .SUM       (ssum),
            .CO        (sco)
        );

        always @(negedge clk) begin : mon_s
            exp_t e;
            if (srst) begin
                sprev <= 1'b0;
            end else begin
                if (sov && !sprev) begin
                    if (sq.size() == 0)
                        chk($sformatf("spurious_out_d%0d", D), 32'(sov), 0);
                    else
                        chk($sformatf("latency_d%0d", D), cyc - sq[0].acc, N);
                end
                if (sov && sq.size() != 0) begin
                    e = sq.pop_front();
                    chk($sformatf("sum_d%0d", D), 32'(ssum), 32'(e.s));
                    chk($sformatf("co_d%0d", D), 32'(sco), 32'(e.c));
                end
                sprev <= sov;
            end
        end

        initial begin
            bit got;
            logic [8:0] t;
            srst = 1'b1;
            siv = 1'b0;
            sa = '0;
            sb = '0;
            sci = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            srst = 1'b0;
            @(posedge clk);
            #1;
            got = 1'b1;
            for (int n = 0; n < 1000 && got; n++) begin
                sa = 8'($urandom);
                sb = 8'($urandom);
                sci = 1'($urandom);
                siv = 1'b1;
                got = 1'b0;
                for (int k = 0; k < 40 && !got; k++) begin
                    @(negedge clk);
                    if (sir) begin
                        got = 1'b1;
                        t = {1'b0, sa} + {1'b0, sb} + {8'b0, sci};
                        sq.push_back('{t[7:0], t[8], cyc + 1});
                    end
                    @(posedge clk);
                    #1;
                end
                if (!got) chk($sformatf("accept_timeout_d%0d", D), 32'(sir), 1);
            end
            siv = 1'b0;
            for (int k = 0; k < 100 && sq.size() != 0; k++) @(negedge clk);
            if (sq.size() != 0) chk($sformatf("drain_timeout_d%0d", D), sq.size(), 0);
            done[g] = 1'b1;
        end
    end

endmodule
